multicycle_control: RTL and testbench

Multicycle MIPS control unit. It replaces the single-cycle opcode decoder with a Moore state machine that sequences fetch, decode, execute, memory and write-back over several clocks. Memory accesses use a `mem_ready` handshake with an optional timeout. Illegal opcodes and bus timeouts raise one-cycle traps. A retired-instruction counter is included. The block drives every datapath mux and enable of the shared-ALU, shared-memory datapath.

---
 rtl/mips_ctrl_pkg.sv | 106 ++++++++++
 rtl/multicycle_control.sv | 233 +++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, FSM state codes,
// datapath select codes and the bundled control-word type.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FUNCT_JR = 6'b001000;

   typedef logic [3:0] state_t;

   localparam state_t S_FETCH  = 4'd0;
   localparam state_t S_DECODE = 4'd1;
   localparam state_t S_MEMADR = 4'd2;
   localparam state_t S_MEMRD  = 4'd3;
   localparam state_t S_MEMWB  = 4'd4;
   localparam state_t S_MEMWR  = 4'd5;
   localparam state_t S_REX    = 4'd6;
   localparam state_t S_RWB    = 4'd7;
   localparam state_t S_IEX    = 4'd8;
   localparam state_t S_IWB    = 4'd9;
   localparam state_t S_BR     = 4'd10;
   localparam state_t S_JMP    = 4'd11;
   localparam state_t S_JR     = 4'd12;
   localparam state_t S_TRAP   = 4'd13;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_FUNCT = 3'b010;
   localparam logic [2:0] ALU_SLT   = 3'b011;
   localparam logic [2:0] ALU_AND   = 3'b100;
   localparam logic [2:0] ALU_OR    = 3'b101;
   localparam logic [2:0] ALU_XOR   = 3'b110;
   localparam logic [2:0] ALU_LUI   = 3'b111;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;
   localparam logic [1:0] PCSRC_REGA   = 2'b11;

   localparam logic [1:0] REGDST_RT = 2'b00;
   localparam logic [1:0] REGDST_RD = 2'b01;
   localparam logic [1:0] REGDST_RA = 2'b10;

   localparam logic [1:0] M2R_ALUOUT = 2'b00;
   localparam logic [1:0] M2R_MDR    = 2'b01;
   localparam logic [1:0] M2R_PC     = 2'b10;

   localparam logic [1:0] SRCB_REGB  = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_BROFF = 2'b11;

   localparam logic [1:0] BR_NONE = 2'b00;
   localparam logic [1:0] BR_EQ   = 2'b01;
   localparam logic [1:0] BR_NE   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic [1:0] branch_op;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       ext_op;
      logic [2:0] alu_op;
      logic [1:0] pc_source;
      logic       trap;
   } ctrl_t;

   function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
      logic [2:0] code;
      code = ALU_ADD;
      case (op)
         OP_SLTI: code = ALU_SLT;
         OP_ANDI: code = ALU_AND;
         OP_ORI:  code = ALU_OR;
         OP_XORI: code = ALU_XOR;
         OP_LUI:  code = ALU_LUI;
         default: code = ALU_ADD;
      endcase
      return code;
   endfunction

   // Logical immediates are zero-extended; everything else sign-extends.
   function automatic logic imm_sign_ext(input logic [5:0] op);
      return !(op == OP_ANDI || op == OP_ORI || op == OP_XORI);
   endfunction

endpackage

// File: rtl/multicycle_control.sv
// Moore control FSM for a shared-ALU, shared-memory multicycle MIPS datapath,
// with mem_ready handshaking, optional bus timeout, traps and a retire counter.
module multicycle_control
   import mips_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT  = 0,
   parameter bit TRAP_ILLEGAL = 1'b1,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic [1:0]       BranchOp,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             RegWrite,
   output logic [1:0]       RegDst,
   output logic [1:0]       MemtoReg,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic             ExtOp,
   output logic [2:0]       ALUOp,
   output logic [1:0]       PCSource,
   output logic             trap,
   output logic             trap_cause,
   output logic [CNT_W-1:0] instret,
   output logic [3:0]       state
);

   localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]  instret_q, instret_d;
   logic              trap_cause_q, trap_cause_d;
   logic              timeout_hit;
   ctrl_t             ctrl;

   // The wait that would complete this cycle's count hits the limit, unless memory answers now.
   always_comb begin
      timeout_hit = 1'b0;
      if (MEM_TIMEOUT != 0 && !mem_ready) begin
         timeout_hit = (32'(wait_cnt_q) + 32'd1) >= 32'(MEM_TIMEOUT);
      end
   end

   always_comb begin
      state_d      = state_q;
      trap_cause_d = trap_cause_q;
      case (state_q)
         S_FETCH: begin
            if (mem_ready) begin
               state_d = S_DECODE;
            end else if (timeout_hit) begin
               state_d      = S_TRAP;
               trap_cause_d = 1'b1;
            end
         end
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW:   state_d = S_MEMADR;
               OP_RTYPE:       state_d = (funct == FUNCT_JR) ? S_JR : S_REX;
               OP_ADDI, OP_SLTI, OP_ANDI,
               OP_ORI, OP_XORI, OP_LUI:
                               state_d = S_IEX;
               OP_BEQ, OP_BNE: state_d = S_BR;
               OP_J, OP_JAL:   state_d = S_JMP;
               default: begin
                  if (TRAP_ILLEGAL) begin
                     state_d      = S_TRAP;
                     trap_cause_d = 1'b0;
                  end else begin
                     state_d = S_FETCH;
                  end
               end
            endcase
         end
         S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD: begin
            if (mem_ready) begin
               state_d = S_MEMWB;
            end else if (timeout_hit) begin
               state_d      = S_TRAP;
               trap_cause_d = 1'b1;
            end
         end
         S_MEMWR: begin
            if (mem_ready) begin
               state_d = S_FETCH;
            end else if (timeout_hit) begin
               state_d      = S_TRAP;
               trap_cause_d = 1'b1;
            end
         end
         S_REX:   state_d = S_RWB;
         S_IEX:   state_d = S_IWB;
         default: state_d = S_FETCH;
      endcase
   end

   // Only the three waiting states ever hold, so any state change is a fresh wait.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (state_d != state_q) begin
         wait_cnt_d = '0;
      end else if (!mem_ready && !(&wait_cnt_q)) begin
         wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      end
   end

   always_comb begin
      instret_d = instret_q;
      if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_TRAP) begin
         instret_d = instret_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_FETCH;
         wait_cnt_q   <= '0;
         instret_q    <= '0;
         trap_cause_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         instret_q    <= instret_d;
         trap_cause_q <= trap_cause_d;
      end
   end

   always_comb begin
      ctrl = '0;
      case (state_q)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         S_DECODE: begin
            ctrl.alu_src_b = SRCB_BROFF;
            ctrl.ext_op    = 1'b1;
         end
         S_MEMADR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.ext_op    = 1'b1;
         end
         S_MEMRD: begin
            ctrl.mem_read = 1'b1;
            ctrl.i_or_d   = 1'b1;
         end
         S_MEMWB: begin
            ctrl.mem_to_reg = M2R_MDR;
            ctrl.reg_write  = 1'b1;
         end
         S_MEMWR: begin
            ctrl.mem_write = 1'b1;
            ctrl.i_or_d    = 1'b1;
         end
         S_REX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_op    = ALU_FUNCT;
         end
         S_RWB: begin
            ctrl.reg_dst   = REGDST_RD;
            ctrl.reg_write = 1'b1;
         end
         S_IEX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = imm_alu_op(opcode);
            ctrl.ext_op    = imm_sign_ext(opcode);
         end
         S_IWB: begin
            ctrl.reg_write = 1'b1;
         end
         S_BR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_op    = ALU_SUB;
            ctrl.pc_source = PCSRC_ALUOUT;
            ctrl.branch_op = (opcode == OP_BEQ) ? BR_EQ : BR_NE;
         end
         S_JMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PCSRC_JUMP;
            if (opcode == OP_JAL) begin
               ctrl.reg_write  = 1'b1;
               ctrl.reg_dst    = REGDST_RA;
               ctrl.mem_to_reg = M2R_PC;
            end
         end
         S_JR: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PCSRC_REGA;
         end
         S_TRAP: begin
            ctrl.trap = 1'b1;
         end
         default: ctrl = '0;
      endcase
      // Reset silences the datapath immediately, not just from the next edge.
      if (reset) begin
         ctrl = '0;
      end
   end

   assign PCWrite    = ctrl.pc_write;
   assign BranchOp   = ctrl.branch_op;
   assign IorD       = ctrl.i_or_d;
   assign MemRead    = ctrl.mem_read;
   assign MemWrite   = ctrl.mem_write;
   assign IRWrite    = ctrl.ir_write;
   assign RegWrite   = ctrl.reg_write;
   assign RegDst     = ctrl.reg_dst;
   assign MemtoReg   = ctrl.mem_to_reg;
   assign ALUSrcA    = ctrl.alu_src_a;
   assign ALUSrcB    = ctrl.alu_src_b;
   assign ExtOp      = ctrl.ext_op;
   assign ALUOp      = ctrl.alu_op;
   assign PCSource   = ctrl.pc_source;
   assign trap       = ctrl.trap;
   assign trap_cause = reset ? 1'b0 : trap_cause_q;
   assign instret    = reset ? '0 : instret_q;
   assign state      = reset ? S_FETCH : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: three control-unit builds (timeout 4 / trapping, timeout 4 / no-trap
// with a 3-bit counter, no timeout / trapping) driven in lockstep and checked every cycle.
module tb_multicycle_control;

   localparam int TO_P [3] = '{4, 4, 0};
   localparam bit TI_P [3] = '{1'b1, 1'b0, 1'b1};
   localparam int CW_P [3] = '{32, 3, 32};

   localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MEMADR = 4'd2, ST_MEMRD = 4'd3;
   localparam logic [3:0] ST_MEMWB = 4'd4, ST_MEMWR = 4'd5, ST_REX = 4'd6, ST_RWB = 4'd7;
   localparam logic [3:0] ST_IEX = 4'd8, ST_IWB = 4'd9, ST_BR = 4'd10, ST_JMP = 4'd11;
   localparam logic [3:0] ST_JR = 4'd12, ST_TRAP = 4'd13;

   localparam logic [5:0] T_RTYPE = 6'b000000, T_J = 6'b000010, T_JAL = 6'b000011;
   localparam logic [5:0] T_BEQ = 6'b000100, T_BNE = 6'b000101, T_ADDI = 6'b001000;
   localparam logic [5:0] T_SLTI = 6'b001010, T_ANDI = 6'b001100, T_ORI = 6'b001101;
   localparam logic [5:0] T_XORI = 6'b001110, T_LUI = 6'b001111, T_LW = 6'b100011;
   localparam logic [5:0] T_SW = 6'b101011, T_ILL = 6'b111111;
   localparam logic [5:0] F_JR = 6'b001000, F_ADD = 6'b100000;

   typedef struct {
      int          unit;
      int          cyc;
      logic [3:0]  st;
      logic [21:0] ctrl;
      logic [31:0] inst;
      logic        tc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_ready;
   logic [5:0]  opcode;
   logic [5:0]  funct;

   logic [21:0] ctrl_o [3];
   logic [3:0]  st_o [3];
   logic [31:0] inst_o [3];
   logic        tc_o [3];

   exp_t        sb [$];
   logic [31:0] inst_m [3];
   logic        tc_m [3];
   logic [2:0]  chk_mask;
   int          n_cyc = 0;
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      logic [CW_P[gi]-1:0] inst_w;
      logic       pcw, ior, mrd, mwr, irw, rw, srca, ext, trp, tc;
      logic [1:0] bop, rdst, m2r, srcb, pcs;
      logic [2:0] aop;
      logic [3:0] st;

      multicycle_control #(
         .MEM_TIMEOUT (TO_P[gi]),
         .TRAP_ILLEGAL(TI_P[gi]),
         .CNT_W       (CW_P[gi])
      ) u_dut (
         .clk       (clk),
         .reset     (reset),
         .opcode    (opcode),
         .funct     (funct),
         .mem_ready (mem_ready),
         .PCWrite   (pcw),
         .BranchOp  (bop),
         .IorD      (ior),
         .MemRead   (mrd),
         .MemWrite  (mwr),
         .IRWrite   (irw),
         .RegWrite  (rw),
         .RegDst    (rdst),
         .MemtoReg  (m2r),
         .ALUSrcA   (srca),
         .ALUSrcB   (srcb),
         .ExtOp     (ext),
         .ALUOp     (aop),
         .PCSource  (pcs),
         .trap      (trp),
         .trap_cause(tc),
         .instret   (inst_w),
         .state     (st)
      );

      assign ctrl_o[gi] = {pcw, bop, ior, mrd, mwr, irw, rw, rdst, m2r, srca, srcb, ext, aop, pcs, trp};
      assign st_o[gi]   = st;
      assign inst_o[gi] = 32'(inst_w);
      assign tc_o[gi]   = tc;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
      end
   endtask

   // Expected control word, straight from the per-state output table.
   function automatic logic [21:0] exp_ctrl(input logic [3:0] st, input logic [5:0] op, input logic mr);
      logic pcw, ior, mrd, mwr, irw, rw, srca, ext, trp;
      logic [1:0] bop, rdst, m2r, srcb, pcs;
      logic [2:0] aop;
      {pcw, ior, mrd, mwr, irw, rw, srca, ext, trp} = '0;
      {bop, rdst, m2r, srcb, pcs, aop} = '0;
      case (st)
         ST_FETCH:  begin mrd = 1'b1; srcb = 2'b01; irw = mr; pcw = mr; end
         ST_DECODE: begin srcb = 2'b11; ext = 1'b1; end
         ST_MEMADR: begin srca = 1'b1; srcb = 2'b10; ext = 1'b1; end
         ST_MEMRD:  begin mrd = 1'b1; ior = 1'b1; end
         ST_MEMWB:  begin m2r = 2'b01; rw = 1'b1; end
         ST_MEMWR:  begin mwr = 1'b1; ior = 1'b1; end
         ST_REX:    begin srca = 1'b1; aop = 3'b010; end
         ST_RWB:    begin rdst = 2'b01; rw = 1'b1; end
         ST_IEX: begin
            srca = 1'b1; srcb = 2'b10;
            case (op)
               T_ADDI: begin aop = 3'b000; ext = 1'b1; end
               T_SLTI: begin aop = 3'b011; ext = 1'b1; end
               T_ANDI: begin aop = 3'b100; ext = 1'b0; end
               T_ORI:  begin aop = 3'b101; ext = 1'b0; end
               T_XORI: begin aop = 3'b110; ext = 1'b0; end
               default: begin aop = 3'b111; ext = 1'b1; end
            endcase
         end
         ST_IWB:    rw = 1'b1;
         ST_BR: begin
            srca = 1'b1; aop = 3'b001; pcs = 2'b01;
            bop = (op == T_BEQ) ? 2'b01 : 2'b10;
         end
         ST_JMP: begin
            pcw = 1'b1; pcs = 2'b10;
            if (op == T_JAL) begin rw = 1'b1; rdst = 2'b10; m2r = 2'b10; end
         end
         ST_JR:     begin pcw = 1'b1; pcs = 2'b11; end
         ST_TRAP:   trp = 1'b1;
         default:   trp = 1'b0;
      endcase
      return {pcw, bop, ior, mrd, mwr, irw, rw, rdst, m2r, srca, srcb, ext, aop, pcs, trp};
   endfunction

   function automatic logic [31:0] exp_inst(input int u);
      if (CW_P[u] >= 32) return inst_m[u];
      return inst_m[u] & ((32'd1 << CW_P[u]) - 32'd1);
   endfunction

   task automatic push(input int u, input logic [3:0] st);
      exp_t e;
      e.unit = u;
      e.cyc  = n_cyc;
      if (reset) begin
         e.st = '0; e.ctrl = '0; e.inst = '0; e.tc = 1'b0;
      end else begin
         e.st   = st;
         e.ctrl = exp_ctrl(st, opcode, mem_ready);
         e.inst = exp_inst(u);
         e.tc   = tc_m[u];
      end
      sb.push_back(e);
   endtask

   task automatic cycx(input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2, input logic mr);
      logic [3:0] st [3];
      st[0] = s0; st[1] = s1; st[2] = s2;
      mem_ready = mr;
      for (int u = 0; u < 3; u++) begin
         if (chk_mask[u]) push(u, st[u]);
      end
      @(posedge clk);
      #1;
      n_cyc++;
   endtask

   task automatic cyc(input logic [3:0] st, input logic mr);
      cycx(st, st, st, mr);
   endtask

   task automatic retire();
      for (int u = 0; u < 3; u++) begin
         if (chk_mask[u]) inst_m[u] = inst_m[u] + 32'd1;
      end
   endtask

   task automatic zero_models();
      for (int u = 0; u < 3; u++) begin
         inst_m[u] = '0;
         tc_m[u]   = 1'b0;
      end
   endtask

   task automatic instr(input logic [5:0] op, input logic [5:0] fn, input int n,
                        input logic [3:0] s2, input logic [3:0] s3, input logic [3:0] s4);
      opcode = op;
      funct  = fn;
      cyc(ST_FETCH, 1'b1);
      cyc(ST_DECODE, 1'b1);
      if (n > 2) cyc(s2, 1'b1);
      if (n > 3) cyc(s3, 1'b1);
      if (n > 4) cyc(s4, 1'b1);
      retire();
      $display("instr op=%b funct=%b cycles=%0d instret_a=%0d", op, fn, n, inst_m[0]);
   endtask

   always @(negedge clk) begin
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check($sformatf("u%0d/c%0d state", e.unit, e.cyc), 32'(st_o[e.unit]), 32'(e.st));
         check($sformatf("u%0d/c%0d ctrl", e.unit, e.cyc), 32'(ctrl_o[e.unit]), 32'(e.ctrl));
         check($sformatf("u%0d/c%0d instret", e.unit, e.cyc), inst_o[e.unit], e.inst);
         check($sformatf("u%0d/c%0d trap_cause", e.unit, e.cyc), 32'(tc_o[e.unit]), 32'(e.tc));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; mem_ready = 1'b0; opcode = '0; funct = '0;
      chk_mask = 3'b111;
      zero_models();
      @(posedge clk);
      #1;
      cyc(ST_FETCH, 1'b0);
      cyc(ST_FETCH, 1'b1);
      reset = 1'b0;

      // Full instruction mix with memory always ready.
      instr(T_LW,    6'd0,  5, ST_MEMADR, ST_MEMRD, ST_MEMWB);
      instr(T_RTYPE, F_ADD, 4, ST_REX, ST_RWB, ST_FETCH);
      instr(T_RTYPE, F_JR,  3, ST_JR, ST_FETCH, ST_FETCH);
      instr(T_JAL,   6'd0,  3, ST_JMP, ST_FETCH, ST_FETCH);
      instr(T_BEQ,   6'd0,  3, ST_BR, ST_FETCH, ST_FETCH);
      instr(T_BNE,   6'd0,  3, ST_BR, ST_FETCH, ST_FETCH);
      instr(T_J,     6'd0,  3, ST_JMP, ST_FETCH, ST_FETCH);
      instr(T_SW,    6'd0,  4, ST_MEMADR, ST_MEMWR, ST_FETCH);
      instr(T_ADDI,  6'd0,  4, ST_IEX, ST_IWB, ST_FETCH);
      instr(T_SLTI,  6'd0,  4, ST_IEX, ST_IWB, ST_FETCH);
      instr(T_ANDI,  6'd0,  4, ST_IEX, ST_IWB, ST_FETCH);
      instr(T_ORI,   6'd0,  4, ST_IEX, ST_IWB, ST_FETCH);
      instr(T_XORI,  6'd0,  4, ST_IEX, ST_IWB, ST_FETCH);
      instr(T_LUI,   6'd0,  4, ST_IEX, ST_IWB, ST_FETCH);

      // Fetch stall of two cycles, then an lw whose read answers on the fourth wait cycle.
      opcode = T_ADDI;
      cyc(ST_FETCH, 1'b0); cyc(ST_FETCH, 1'b0); cyc(ST_FETCH, 1'b1);
      cyc(ST_DECODE, 1'b1); cyc(ST_IEX, 1'b1); cyc(ST_IWB, 1'b1);
      retire();
      $display("instr op=%b fetch-stall instret_a=%0d", opcode, inst_m[0]);
      opcode = T_LW;
      cyc(ST_FETCH, 1'b1); cyc(ST_DECODE, 1'b1); cyc(ST_MEMADR, 1'b1);
      cyc(ST_MEMRD, 1'b0); cyc(ST_MEMRD, 1'b0); cyc(ST_MEMRD, 1'b0); cyc(ST_MEMRD, 1'b1);
      cyc(ST_MEMWB, 1'b1);
      retire();
      $display("instr op=%b read-stall instret_a=%0d", opcode, inst_m[0]);

      // sw with memory never answering: units with a timeout trap, the other keeps waiting.
      opcode = T_SW;
      cyc(ST_FETCH, 1'b1); cyc(ST_DECODE, 1'b1); cyc(ST_MEMADR, 1'b1);
      for (int i = 0; i < 4; i++) cyc(ST_MEMWR, 1'b0);
      tc_m[0] = 1'b1;
      tc_m[1] = 1'b1;
      cycx(ST_TRAP, ST_TRAP, ST_MEMWR, 1'b0);
      cycx(ST_FETCH, ST_FETCH, ST_MEMWR, 1'b0);
      $display("instr op=%b bus timeout instret_a=%0d", opcode, inst_m[0]);

      // Same sw with mem_ready arriving on the fourth wait cycle retires normally.
      chk_mask = 3'b011;
      cyc(ST_FETCH, 1'b1); cyc(ST_DECODE, 1'b1); cyc(ST_MEMADR, 1'b1);
      cyc(ST_MEMWR, 1'b0); cyc(ST_MEMWR, 1'b0); cyc(ST_MEMWR, 1'b0); cyc(ST_MEMWR, 1'b1);
      retire();
      $display("instr op=%b late ready instret_a=%0d", opcode, inst_m[0]);

      // Illegal opcode: unit 0 traps, unit 1 retires it as a no-op.
      opcode = T_ILL;
      cyc(ST_FETCH, 1'b1); cyc(ST_DECODE, 1'b1);
      tc_m[0] = 1'b0;
      inst_m[1] = inst_m[1] + 32'd1;
      cycx(ST_TRAP, ST_FETCH, ST_FETCH, 1'b1);
      $display("instr op=%b illegal instret_a=%0d instret_b=%0d", opcode, inst_m[0], exp_inst(1));

      // Re-align all units, then abort an lw with reset while it waits in MEMRD.
      reset = 1'b1;
      chk_mask = 3'b111;
      cyc(ST_FETCH, 1'b0);
      cyc(ST_FETCH, 1'b0);
      zero_models();
      reset = 1'b0;
      instr(T_RTYPE, F_ADD, 4, ST_REX, ST_RWB, ST_FETCH);
      opcode = T_LW;
      cyc(ST_FETCH, 1'b1); cyc(ST_DECODE, 1'b1); cyc(ST_MEMADR, 1'b1); cyc(ST_MEMRD, 1'b0);
      reset = 1'b1;
      cyc(ST_MEMRD, 1'b0);
      zero_models();
      cyc(ST_FETCH, 1'b0);
      reset = 1'b0;
      cyc(ST_FETCH, 1'b0);
      $display("instr op=%b aborted by reset instret_a=%0d", opcode, inst_m[0]);
      instr(T_LW, 6'd0, 5, ST_MEMADR, ST_MEMRD, ST_MEMWB);
      cyc(ST_FETCH, 1'b0);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
